// File: rtl/fp_align_pkg.sv
// fp_align_pkg
// Shared constants, state encoding and unpack helpers for the
// single-precision operand aligner (front end of the FP adder).
// No ports: imported by the interface, the shifter and the top.
package fp_align_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int MANT_W    = 27;
    localparam int SAT_SHIFT = 27;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Denormals and zero behave as if their exponent were 1.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? 8'd1 : e;
    endfunction

    // {hidden, frac, G, R, S} with guard/round/sticky starting at zero.
    function automatic logic [MANT_W-1:0] unpack_mant(input logic [31:0] x);
        logic hidden;
        hidden = |x[30:23];
        return {hidden, x[22:0], 3'b000};
    endfunction

endpackage

// File: rtl/fp_operand_aligner_if.sv
// fp_operand_aligner_if
// Bundles the operand (input) and aligned-result (output) valid/ready
// channels of the aligner.
//   master : upstream/downstream side, drives in_* and out_ready
//   slave  : the aligner, drives in_ready and all out_* results
interface fp_operand_aligner_if;
    import fp_align_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_a;
    logic [31:0]         in_b;
    logic                out_valid;
    logic                out_ready;
    logic [EXP_W-1:0]    out_exp;
    logic [MANT_W-1:0]   out_mant_big;
    logic [MANT_W-1:0]   out_mant_small;
    logic                out_sign_big;
    logic                out_sign_small;
    logic                out_eff_sub;
    logic                out_swapped;
    logic                out_special;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_exp, out_mant_big, out_mant_small,
               out_sign_big, out_sign_small, out_eff_sub, out_swapped,
               out_special
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_exp, out_mant_big, out_mant_small,
               out_sign_big, out_sign_small, out_eff_sub, out_swapped,
               out_special
    );

endinterface

// File: rtl/fp_sticky_shifter.sv
// fp_sticky_shifter
// Combinational right shift of a 27-bit GRS mantissa with sticky
// accumulation into bit 0.
//   mant_i  : mantissa before this shift step
//   shamt_i : shift distance, 0..27 (the caller limits it to SHIFT_STEP)
//   mant_o  : shifted mantissa; bit0 = OR of shifted-out bits, the new
//             bit0 and the old bit0, so a set sticky bit never clears
module fp_sticky_shifter
    import fp_align_pkg::*;
(
    input  logic [MANT_W-1:0] mant_i,
    input  logic [4:0]        shamt_i,
    output logic [MANT_W-1:0] mant_o
);

    logic [MANT_W-1:0] shifted;
    logic [MANT_W-1:0] lost_mask;
    logic              sticky;

    always_comb begin
        shifted   = mant_i >> shamt_i;
        // Ones in the positions that fall off the right end.
        lost_mask = ~({MANT_W{1'b1}} << shamt_i);
        sticky    = (|(mant_i & lost_mask)) | shifted[0] | mant_i[0];
        mant_o    = {shifted[MANT_W-1:1], sticky};
    end

endmodule

// File: rtl/fp_operand_aligner.sv
// fp_operand_aligner
// Unpacks two binary32 operands, orders them by effective exponent and
// right-aligns the smaller mantissa up to SHIFT_STEP bits per cycle with
// sticky accumulation, presenting the result on a valid/ready channel.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of fp_operand_aligner_if (operands in, aligned
//           mantissas / common exponent / sign info out)
module fp_operand_aligner
    import fp_align_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_operand_aligner_if.slave  bus
);

    localparam logic [EXP_W-1:0] STEP_EXP = EXP_W'(SHIFT_STEP);
    localparam logic [EXP_W-1:0] SAT_EXP  = EXP_W'(SAT_SHIFT);

    state_e            state_q;
    logic [EXP_W-1:0]  exp_q;
    logic [MANT_W-1:0] mant_big_q;
    logic [MANT_W-1:0] mant_small_q;
    logic              sign_big_q;
    logic              sign_small_q;
    logic              swapped_q;
    logic              special_q;
    logic              out_valid_q;
    logic [EXP_W-1:0]  remaining_q;

    logic [EXP_W-1:0]  eff_exp_a, eff_exp_b, big_exp_d, small_exp_d, diff_d;
    logic [MANT_W-1:0] mant_a, mant_b, mant_big_d, mant_small_d, mant_shifted_d;
    logic              b_bigger_d, special_d;
    logic [4:0]        step_d;
    logic [EXP_W-1:0]  remaining_d;

    // Unpack and order the incoming pair; ties keep A as the big operand.
    always_comb begin
        eff_exp_a    = eff_exp(bus.in_a[30:23]);
        eff_exp_b    = eff_exp(bus.in_b[30:23]);
        mant_a       = unpack_mant(bus.in_a);
        mant_b       = unpack_mant(bus.in_b);
        b_bigger_d   = eff_exp_b > eff_exp_a;
        big_exp_d    = b_bigger_d ? eff_exp_b : eff_exp_a;
        small_exp_d  = b_bigger_d ? eff_exp_a : eff_exp_b;
        mant_big_d   = b_bigger_d ? mant_b : mant_a;
        mant_small_d = b_bigger_d ? mant_a : mant_b;
        diff_d       = big_exp_d - small_exp_d;
        special_d    = (bus.in_a[30:23] == EXP_SPECIAL) ||
                       (bus.in_b[30:23] == EXP_SPECIAL);
    end

    // Shift distance for this ALIGN cycle; remaining is below 27 here,
    // so its low five bits hold the whole value.
    always_comb begin
        step_d      = (remaining_q < STEP_EXP) ? remaining_q[4:0] : 5'(SHIFT_STEP);
        remaining_d = remaining_q - {3'b000, step_d};
    end

    fp_sticky_shifter u_shifter (
        .mant_i  (mant_small_q),
        .shamt_i (step_d),
        .mant_o  (mant_shifted_d)
    );

    // Control FSM and result registers. Special operands skip alignment
    // entirely; shifts of 27 or more collapse to a lone sticky bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            exp_q        <= '0;
            mant_big_q   <= '0;
            mant_small_q <= '0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            swapped_q    <= 1'b0;
            special_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            remaining_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        exp_q        <= big_exp_d;
                        mant_big_q   <= mant_big_d;
                        sign_big_q   <= b_bigger_d ? bus.in_b[31] : bus.in_a[31];
                        sign_small_q <= b_bigger_d ? bus.in_a[31] : bus.in_b[31];
                        swapped_q    <= b_bigger_d;
                        special_q    <= special_d;
                        remaining_q  <= '0;
                        if (special_d || diff_d == '0) begin
                            mant_small_q <= mant_small_d;
                            out_valid_q  <= 1'b1;
                            state_q      <= DONE;
                        end else if (diff_d >= SAT_EXP) begin
                            mant_small_q <= {{(MANT_W-1){1'b0}}, |mant_small_d};
                            out_valid_q  <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            mant_small_q <= mant_small_d;
                            remaining_q  <= diff_d;
                            state_q      <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    mant_small_q <= mant_shifted_d;
                    remaining_q  <= remaining_d;
                    if (remaining_d == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // in_ready is held low while reset is asserted, even before the
    // reset edge has returned the FSM to IDLE.
    assign bus.in_ready       = rst_n && (state_q == IDLE);
    assign bus.out_valid      = out_valid_q;
    assign bus.out_exp        = exp_q;
    assign bus.out_mant_big   = mant_big_q;
    assign bus.out_mant_small = mant_small_q;
    assign bus.out_sign_big   = sign_big_q;
    assign bus.out_sign_small = sign_small_q;
    assign bus.out_eff_sub    = sign_big_q ^ sign_small_q;
    assign bus.out_swapped    = swapped_q;
    assign bus.out_special    = special_q;

endmodule

// File: tb/tb_fp_operand_aligner.sv
// tb_fp_operand_aligner
// Directed self-checking bench for fp_operand_aligner (SHIFT_STEP=4).
// Each scenario task drives operands and compares results against
// hand-computed values.
module tb_fp_operand_aligner;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fp_operand_aligner_if bus ();

    fp_operand_aligner #(.SHIFT_STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10-unit clock; inputs change and outputs are sampled away from posedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand pair for a single accept edge.
    task automatic startOp(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Accept a pair and count edges (accept edge included) until out_valid.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 output int lat);
        startOp(a, b);
        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) lat = 99;
    endtask

    // One-cycle output handshake.
    task automatic drainResult();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h3F800000;
        bus.in_b     = 32'h40000000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_exp !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_exp: got %h want 00", bus.out_exp); end
        checks++; if (bus.out_mant_small !== 27'h0) begin errors++; $display("[TB] FAIL reset_mant_small: got %h want 0", bus.out_mant_small); end
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_equal();
        int lat;
        applyStimulus(32'h3F800000, 32'h3F800000, lat);
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL equal_latency: got %0d want 1", lat); end
        checks++; if (bus.out_exp !== 8'h7F) begin errors++; $display("[TB] FAIL equal_exp: got %h want 7f", bus.out_exp); end
        checks++; if (bus.out_mant_big !== 27'h4000000) begin errors++; $display("[TB] FAIL equal_mant_big: got %h want 4000000", bus.out_mant_big); end
        checks++; if (bus.out_mant_small !== 27'h4000000) begin errors++; $display("[TB] FAIL equal_mant_small: got %h want 4000000", bus.out_mant_small); end
        checks++; if (bus.out_swapped !== 1'b0) begin errors++; $display("[TB] FAIL equal_swapped: got %b want 0", bus.out_swapped); end
        checks++; if (bus.out_eff_sub !== 1'b0) begin errors++; $display("[TB] FAIL equal_eff_sub: got %b want 0", bus.out_eff_sub); end
        checks++; if (bus.out_special !== 1'b0) begin errors++; $display("[TB] FAIL equal_special: got %b want 0", bus.out_special); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL equal_in_ready_done: got %b want 0", bus.in_ready); end
        drainResult();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL equal_valid_after_hs: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL equal_in_ready_idle: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_diff26();
        int lat;
        applyStimulus(32'h3F800000, 32'h32800000, lat);
        checks++; if (lat !== 8) begin errors++; $display("[TB] FAIL diff26_latency: got %0d want 8", lat); end
        checks++; if (bus.out_mant_small !== 27'h0000001) begin errors++; $display("[TB] FAIL diff26_mant_small: got %h want 0000001", bus.out_mant_small); end
        checks++; if (bus.out_exp !== 8'h7F) begin errors++; $display("[TB] FAIL diff26_exp: got %h want 7f", bus.out_exp); end
        drainResult();
    endtask

    task automatic test_diff27();
        int lat;
        applyStimulus(32'h3F800000, 32'h32000001, lat);
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL diff27_latency: got %0d want 1", lat); end
        checks++; if (bus.out_mant_small !== 27'h0000001) begin errors++; $display("[TB] FAIL diff27_mant_small: got %h want 0000001", bus.out_mant_small); end
        checks++; if (bus.out_mant_big !== 27'h4000000) begin errors++; $display("[TB] FAIL diff27_mant_big: got %h want 4000000", bus.out_mant_big); end
        drainResult();
    endtask

    task automatic test_swap();
        int lat;
        applyStimulus(32'h3F000000, 32'hC0000000, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL swap_latency: got %0d want 2", lat); end
        checks++; if (bus.out_swapped !== 1'b1) begin errors++; $display("[TB] FAIL swap_swapped: got %b want 1", bus.out_swapped); end
        checks++; if (bus.out_exp !== 8'h80) begin errors++; $display("[TB] FAIL swap_exp: got %h want 80", bus.out_exp); end
        checks++; if (bus.out_sign_big !== 1'b1) begin errors++; $display("[TB] FAIL swap_sign_big: got %b want 1", bus.out_sign_big); end
        checks++; if (bus.out_sign_small !== 1'b0) begin errors++; $display("[TB] FAIL swap_sign_small: got %b want 0", bus.out_sign_small); end
        checks++; if (bus.out_eff_sub !== 1'b1) begin errors++; $display("[TB] FAIL swap_eff_sub: got %b want 1", bus.out_eff_sub); end
        checks++; if (bus.out_mant_small !== 27'h1000000) begin errors++; $display("[TB] FAIL swap_mant_small: got %h want 1000000", bus.out_mant_small); end
        checks++; if (bus.out_mant_big !== 27'h4000000) begin errors++; $display("[TB] FAIL swap_mant_big: got %h want 4000000", bus.out_mant_big); end
        drainResult();
    endtask

    task automatic test_denormal();
        int lat;
        applyStimulus(32'h00800000, 32'h00000001, lat);
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL denorm_latency: got %0d want 1", lat); end
        checks++; if (bus.out_exp !== 8'h01) begin errors++; $display("[TB] FAIL denorm_exp: got %h want 01", bus.out_exp); end
        checks++; if (bus.out_mant_big !== 27'h4000000) begin errors++; $display("[TB] FAIL denorm_mant_big: got %h want 4000000", bus.out_mant_big); end
        checks++; if (bus.out_mant_small !== 27'h0000008) begin errors++; $display("[TB] FAIL denorm_mant_small: got %h want 0000008", bus.out_mant_small); end
        checks++; if (bus.out_swapped !== 1'b0) begin errors++; $display("[TB] FAIL denorm_swapped: got %b want 0", bus.out_swapped); end
        drainResult();
    endtask

    // Infinity against 1.0: diff would saturate, but specials stay unshifted.
    task automatic test_special();
        int lat;
        applyStimulus(32'h7F800000, 32'h3F800000, lat);
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL special_latency: got %0d want 1", lat); end
        checks++; if (bus.out_special !== 1'b1) begin errors++; $display("[TB] FAIL special_flag: got %b want 1", bus.out_special); end
        checks++; if (bus.out_exp !== 8'hFF) begin errors++; $display("[TB] FAIL special_exp: got %h want ff", bus.out_exp); end
        checks++; if (bus.out_mant_small !== 27'h4000000) begin errors++; $display("[TB] FAIL special_mant_small: got %h want 4000000", bus.out_mant_small); end
        drainResult();
    endtask

    // diff 5: a 4-bit step then a 1-bit step, sticky gathered from frac bits.
    task automatic test_sticky_multi();
        int lat;
        applyStimulus(32'h3F800000, 32'h3D000003, lat);
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL sticky_latency: got %0d want 3", lat); end
        checks++; if (bus.out_mant_small !== 27'h0200001) begin errors++; $display("[TB] FAIL sticky_mant_small: got %h want 0200001", bus.out_mant_small); end
        drainResult();
    endtask

    task automatic test_back_to_back();
        int lat;
        applyStimulus(32'h40400000, 32'h3F800000, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL b2b1_latency: got %0d want 2", lat); end
        checks++; if (bus.out_mant_big !== 27'h6000000) begin errors++; $display("[TB] FAIL b2b1_mant_big: got %h want 6000000", bus.out_mant_big); end
        checks++; if (bus.out_mant_small !== 27'h2000000) begin errors++; $display("[TB] FAIL b2b1_mant_small: got %h want 2000000", bus.out_mant_small); end
        drainResult();
        applyStimulus(32'h3F800000, 32'h3E800001, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL b2b2_latency: got %0d want 2", lat); end
        checks++; if (bus.out_mant_small !== 27'h1000002) begin errors++; $display("[TB] FAIL b2b2_mant_small: got %h want 1000002", bus.out_mant_small); end
        checks++; if (bus.out_exp !== 8'h7F) begin errors++; $display("[TB] FAIL b2b2_exp: got %h want 7f", bus.out_exp); end
        drainResult();
    endtask

    // Hold DONE for 10 cycles while also offering a new (ignored) pair.
    task automatic test_backpressure();
        int lat;
        applyStimulus(32'h3F000000, 32'hC0000000, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL bp_latency: got %0d want 2", lat); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a     = 32'h12345678;
            bus.in_b     = 32'h3F800000;
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_exp !== 8'h80 ||
                bus.out_mant_small !== 27'h1000000 || bus.out_swapped !== 1'b1 || bus.out_sign_big !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d: got valid=%b ready=%b exp=%h ms=%h sw=%b sb=%b want 1 0 80 1000000 1 1",
                         i, bus.out_valid, bus.in_ready, bus.out_exp, bus.out_mant_small, bus.out_swapped, bus.out_sign_big);
            end
        end
        bus.in_valid = 1'b0;
        drainResult();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_after_hs: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_align();
        int stray;
        stray = 0;
        startOp(32'h3F800000, 32'h32800000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_mant_small !== 27'h0) begin errors++; $display("[TB] FAIL midrst_mant_small: got %h want 0", bus.out_mant_small); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL midrst_stray_valid: got %0d cycles want 0", stray); end
    endtask

    // Guard against a hung simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_equal();
        test_diff26();
        test_diff27();
        test_swap();
        test_denormal();
        test_special();
        test_sticky_multi();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_align();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_operand_aligner.md
Name: fp_operand_aligner

Overview:
- Front-end stage of the single-precision floating-point adder; feeds the 27-bit guard/round/sticky mantissa format that the post-add rounding stage consumes.
- Accepts two IEEE-754 binary32 operands and unpacks them. Orders them by exponent, then right-shifts the smaller mantissa iteratively with sticky accumulation.
- Presents both aligned 27-bit mantissas plus the common exponent on a valid/ready interface.

Parameters:
SHIFT_STEP, 4, maximum right-shift bit positions per ALIGN cycle (legal 1..27)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_a  input  32  operand A, binary32
in_b  input  32  operand B, binary32
out_valid  output  1  aligned result valid
out_ready  input  1  downstream accepts result
out_exp  output  8  common (larger effective) exponent
out_mant_big  output  27  larger-exponent mantissa {hidden, frac[22:0], G, R, S}
out_mant_small  output  27  aligned smaller-exponent mantissa, same format
out_sign_big  output  1  sign of larger-exponent operand
out_sign_small  output  1  sign of smaller-exponent operand
out_eff_sub  output  1  sign_big XOR sign_small
out_swapped  output  1  1 when B is the larger-exponent operand
out_special  output  1  either operand has exponent 255 (Inf/NaN)

Behaviour:
- Reset: the state machine goes to IDLE and all registered outputs clear to 0. in_ready is 0 while rst_n is low and 1 in IDLE afterwards.
- Reset mid-operation: a pending or partial result is discarded and no output handshake occurs.
- Unpack rules:
  - exp==0 gives hidden=0 and effective exponent 1 (denormal/zero).
  - Otherwise hidden=1 and effective exponent = exp.
  - 27-bit mantissa = {hidden, frac, 3'b000}.
- Ordering: when eff_exp_b > eff_exp_a, B is big and swapped=1. On ties A is big.
- diff = eff_exp_big - eff_exp_small, as an 8-bit unsigned value.
- States: IDLE, ALIGN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture on that edge:
    - special operands (exp 255 on either input): go to DONE with mantissas unshifted.
    - diff==0: go to DONE.
    - diff>=27: go to DONE. mant_small = {26'b0, OR of all small-mantissa bits}.
    - otherwise: go to ALIGN with remaining = diff.
- ALIGN:
  - Each edge shifts mant_small right by s = min(remaining, SHIFT_STEP).
  - New bit0 = OR(shifted-out bits, shifted value bit0, old bit0). Sticky never clears.
  - remaining -= s. When the result reaches 0, go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1 and all out_* are held stable.
  - On out_ready, move to IDLE. in_ready rises the cycle after, giving one bubble per operation.
- Latency from accept edge to out_valid high:
  - 1 cycle when diff==0, diff>=27 or special.
  - Otherwise 1 + ceil(diff/SHIFT_STEP) cycles.
- out_exp is the big operand's effective exponent; it is 1 (not 0) when both operands are denormal.
- out_eff_sub is combinational from the registered signs. No other combinational paths from inputs to outputs.
- Backpressure: DONE may hold indefinitely and outputs must not change while out_ready=0.
- in_valid while not in IDLE is ignored; there is no buffering.

Decomposition:
- Package fp_align_pkg:
  - constants EXP_W=8, FRAC_W=23, MANT_W=27, EXP_SPECIAL=8'hFF, SAT_SHIFT=27
  - state encoding IDLE/ALIGN/DONE
- One sub-module, fp_sticky_shifter: combinational right shift of 27 bits by 0..SHIFT_STEP with a sticky OR into bit0, instantiated once in the ALIGN datapath.

Test Plan:
- in_a=0x3F800000, in_b=0x3F800000 -> after 1 cycle: out_exp=0x7F, mant_big=mant_small=0x4000000, swapped=0, eff_sub=0.
- in_a=0x3F800000, in_b=0x32800000 (diff 26), SHIFT_STEP=4 -> out_valid 8 cycles after accept: mant_small=0x0000001, out_exp=0x7F.
- in_a=0x3F800000, in_b=0x32000001 (diff 27) -> 1-cycle latency: mant_small=0x0000001 (sticky only).
- in_a=0x3F000000, in_b=0xC0000000 -> swapped=1, out_exp=0x80, sign_big=1, eff_sub=1, mant_small=0x1000000, latency 2.
- in_a=0x00800000, in_b=0x00000001 (denormal, diff 0) -> out_exp=0x01, mant_big=0x4000000, mant_small=0x0000008.
- Protocol checks:
  - Hold out_ready=0 for 10 cycles in DONE: outputs stable, in_ready=0.
  - Separately, drive rst_n=0 for one edge mid-ALIGN: next cycle state is IDLE, out_valid=0, in_ready=1 after release, and no stray output handshake.
